// File: rtl/regfile_sb_if.sv
// Bus between decode/writeback and the scoreboarded register file.
// The master drives writes, reads, issue reservations and clear requests; the slave answers.
interface regfile_sb_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [XLEN-1:0]   wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output we, wa, wd, ra1, ra2, issue_valid, issue_rd, clr_req,
    input  rd1, rd2, rs1_busy, rs2_busy, clr_busy
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, issue_valid, issue_rd, clr_req,
    output rd1, rd2, rs1_busy, rs2_busy, clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised integer register file with write-to-read bypass, a per-register
// pending-write scoreboard and a walking bulk-clear engine.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rstn,
  regfile_sb_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] CLR_START = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [NREGS-1:0]  pending_q, pending_d;

  logic idle;
  logic wr_eff;
  logic iss_eff;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign idle    = (state_q == ST_IDLE);
  assign wr_eff  = bus.we && idle && !is_zero(bus.wa);
  assign iss_eff = bus.issue_valid && idle && !is_zero(bus.issue_rd);

  // NOTE: always_comb uses blocking '=' and assigns every output a default first,
  // so no latch is inferred; the flops below use non-blocking '<=' only.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    regs_d    = regs_q;
    pending_d = pending_q;
    if (state_q == ST_IDLE) begin
      if (wr_eff) begin
        regs_d[bus.wa]    = bus.wd;
        pending_d[bus.wa] = 1'b0;
      end
      // Applied after the write so a same-cycle reservation wins.
      if (iss_eff) begin
        pending_d[bus.issue_rd] = 1'b1;
      end
      if (bus.clr_req) begin
        state_d = ST_CLEAR;
        idx_d   = CLR_START;
      end
    end else begin
      regs_d[idx_q]    = '0;
      pending_d[idx_q] = 1'b0;
      idx_d            = idx_q + ADDR_W'(1);
      if (idx_q == LAST_IDX) begin
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: the storage array is reset on purpose: the architectural reset state is
  // all-zero registers, so this cannot be mapped onto a reset-less RAM macro.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      regs_q    <= regs_d;
    end
  end

  // Bypass only through wr_eff, which depends on state and not on clr_req.
  assign bus.rd1 = is_zero(bus.ra1) ? '0 :
                   (wr_eff && (bus.wa == bus.ra1)) ? bus.wd : regs_q[bus.ra1];
  assign bus.rd2 = is_zero(bus.ra2) ? '0 :
                   (wr_eff && (bus.wa == bus.ra2)) ? bus.wd : regs_q[bus.ra2];

  assign bus.rs1_busy = idle && !is_zero(bus.ra1) && pending_q[bus.ra1] &&
                        !(wr_eff && (bus.wa == bus.ra1));
  assign bus.rs2_busy = idle && !is_zero(bus.ra2) && pending_q[bus.ra2] &&
                        !(wr_eff && (bus.wa == bus.ra2));

  assign bus.clr_busy = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: expectations are queued when stimulus is
// driven and popped against the DUT outputs once they settle.
module tb_regfile_sb;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  regfile_sb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    string           tag;
    logic [XLEN-1:0] exp;
  } sb_t;

  sb_t             sb_q [$];
  int              n_checks = 0;
  int              n_errors = 0;
  logic [XLEN-1:0] model [32];
  int              cnt;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [XLEN-1:0] v);
    sb_q.push_back('{tag, v});
  endtask

  task automatic observe(input logic [XLEN-1:0] got);
    sb_t e;
    if (sb_q.size() == 0) e = '{"sb_empty", ~got};
    else                  e = sb_q.pop_front();
    check(e.tag, got, e.exp);
  endtask

  task automatic clear_inputs();
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.ra1 = '0; bus.ra2 = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset state
    bus.ra1 = 5'd3; bus.ra2 = 5'd17;
    #2;
    expect_val("rst_rd1", 0);      observe(bus.rd1);
    expect_val("rst_rd2", 0);      observe(bus.rd2);
    expect_val("rst_rs1_busy", 0); observe(bus.rs1_busy);
    expect_val("rst_rs2_busy", 0); observe(bus.rs2_busy);
    expect_val("rst_clr_busy", 0); observe(bus.clr_busy);
    @(negedge clk);
    rstn = 1'b1;

    // Same-cycle bypass, then storage
    next_cycle();
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF; bus.ra1 = 5'd5;
    model[5] = 32'hDEADBEEF;
    expect_val("bypass_rd1", model[5]);
    @(negedge clk); observe(bus.rd1);
    next_cycle();
    bus.we = 1'b0;
    expect_val("stored_rd1", model[5]);
    @(negedge clk); observe(bus.rd1);

    // Hard-wired zero register ignores writes and reservations
    next_cycle();
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'h1234;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.ra1 = 5'd0;
    expect_val("x0_rd1_wr", 0);   expect_val("x0_busy_wr", 0);
    @(negedge clk); observe(bus.rd1); observe(bus.rs1_busy);
    next_cycle();
    clear_inputs();
    expect_val("x0_rd1_after", 0); expect_val("x0_busy_after", 0);
    @(negedge clk); observe(bus.rd1); observe(bus.rs1_busy);

    // Hazard on x7: reserve, observe busy, resolve via writeback
    next_cycle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.ra2 = 5'd7;
    expect_val("x7_busy_issue_cycle", 0);
    @(negedge clk); observe(bus.rs2_busy);
    next_cycle();
    bus.issue_valid = 1'b0;
    expect_val("x7_busy_pending", 1);
    @(negedge clk); observe(bus.rs2_busy);
    next_cycle();
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h55; model[7] = 32'h55;
    expect_val("x7_busy_wb", 0); expect_val("x7_rd2_wb", model[7]);
    @(negedge clk); observe(bus.rs2_busy); observe(bus.rd2);
    next_cycle();
    bus.we = 1'b0;
    expect_val("x7_busy_after", 0); expect_val("x7_rd2_after", model[7]);
    @(negedge clk); observe(bus.rs2_busy); observe(bus.rd2);

    // Issue and write x9 in the same cycle: data stored, reservation wins
    next_cycle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h1; model[9] = 32'h1;
    next_cycle();
    clear_inputs(); bus.ra1 = 5'd9;
    expect_val("x9_rd1", model[9]); expect_val("x9_busy", 1);
    @(negedge clk); observe(bus.rd1); observe(bus.rs1_busy);

    // Fill x1..x31 with nonzero data
    for (int i = 1; i < 32; i++) begin
      next_cycle();
      bus.we = 1'b1; bus.wa = 5'(i); bus.wd = (32'(i) * 32'h01010101) ^ 32'hA5000000;
      bus.ra1 = 5'(i);
      model[i] = bus.wd;
      expect_val($sformatf("fill_rd1_x%0d", i), model[i]);
      @(negedge clk); observe(bus.rd1);
    end
    next_cycle();
    bus.we = 1'b0;
    foreach (model[i]) begin end
    for (int k = 0; k < 3; k++) begin
      bus.issue_valid = 1'b1;
      bus.issue_rd = (k == 0) ? 5'd2 : (k == 1) ? 5'd4 : 5'd30;
      next_cycle();
    end
    clear_inputs(); bus.ra1 = 5'd4; bus.ra2 = 5'd30;
    expect_val("pre_clr_busy4", 1); expect_val("pre_clr_busy30", 1);
    expect_val("pre_clr_rd1", model[4]);
    @(negedge clk); observe(bus.rs1_busy); observe(bus.rs2_busy); observe(bus.rd1);

    // Bulk clear with a write and an issue attempted mid-clear
    next_cycle();
    bus.clr_req = 1'b1;
    next_cycle();
    bus.clr_req = 1'b0; bus.ra1 = 5'd3; bus.ra2 = 5'd30;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.clr_busy) break;
      cnt++;
      if (cnt == 5) begin
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hBAD;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd2;
        #1;
        expect_val("clr_rd1_no_bypass", 0); observe(bus.rd1);
        expect_val("clr_rs2_forced", 0);    observe(bus.rs2_busy);
      end else if (cnt == 6) begin
        bus.we = 1'b0; bus.issue_valid = 1'b0;
      end
    end
    for (int i = 0; i < 32; i++) model[i] = '0;
    expect_val("clr_cycles", 31);
    observe(cnt);

    for (int i = 0; i < 32; i++) begin
      next_cycle();
      bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i);
      expect_val($sformatf("post_clr_rd1_x%0d", i), model[i]);
      expect_val($sformatf("post_clr_busy1_x%0d", i), 0);
      expect_val($sformatf("post_clr_busy2_x%0d", 31 - i), 0);
      @(negedge clk); observe(bus.rd1); observe(bus.rs1_busy); observe(bus.rs2_busy);
    end

    // Reset in the middle of a clear
    next_cycle();
    bus.we = 1'b1; bus.wa = 5'd31; bus.wd = 32'h77; model[31] = 32'h77;
    next_cycle();
    bus.we = 1'b0; bus.issue_valid = 1'b1; bus.issue_rd = 5'd31;
    next_cycle();
    clear_inputs(); bus.clr_req = 1'b1;
    next_cycle();
    bus.clr_req = 1'b0; bus.ra1 = 5'd31; bus.ra2 = 5'd31;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.clr_busy) cnt++;
      if (cnt == 10) break;
    end
    expect_val("mid_clr_busy", 1);      observe(bus.clr_busy);
    expect_val("mid_clr_rd1", model[31]); observe(bus.rd1);
    expect_val("mid_clr_rs2", 0);       observe(bus.rs2_busy);
    #2;
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    expect_val("async_rst_rd1", model[31]); observe(bus.rd1);
    expect_val("async_rst_rd2", model[31]); observe(bus.rd2);
    expect_val("async_rst_clr_busy", 0);    observe(bus.clr_busy);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) next_cycle();
    expect_val("post_rst_clr_busy", 0); expect_val("post_rst_rd1", 0);
    expect_val("post_rst_rs1_busy", 0);
    @(negedge clk); observe(bus.clr_busy); observe(bus.rd1); observe(bus.rs1_busy);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
